// File: rtl/sphere_hit_scanner.sv
// Sphere table scanner feeding a combinational ray/sphere collision unit.
// On an accepted start it latches one ray, walks the sphere table one entry
// per three cycles (FETCH, LOAD, EVAL) and keeps the nearest accepted hit.
//
// Ports:
//   Clk, Reset          clock and synchronous active-high reset
//   start               one-cycle scan request, honoured only when idle
//   ray_origin/ray_dir  ray latched on an accepted start (Q16.16 x3)
//   num_spheres         valid table entries, clamped to MAX_SPHERES
//   sphere_addr         table read address; sphere_data returns a cycle later
//   cd_sphere/cd_ray    relative centre and direction to the collision unit
//   cd_tbest            running best distance to the collision unit
//   cd_tnew/cd_collide  candidate distance and hit flag from the collision unit
//   busy/done           scan in progress / one-cycle result strobe
//   hit/hit_index/t_hit nearest hit result
module sphere_hit_scanner #(
  parameter int unsigned MAX_SPHERES = 16,
  parameter int unsigned IDX_W       = 4,
  parameter logic [31:0] TMAX        = 32'h7FFF_FFFF,
  parameter logic [31:0] TMIN        = 32'h0000_0100
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [95:0]      ray_origin,
  input  logic [95:0]      ray_dir,
  input  logic [IDX_W:0]   num_spheres,
  output logic [IDX_W-1:0] sphere_addr,
  input  logic [95:0]      sphere_data,
  output logic [95:0]      cd_sphere,
  output logic [95:0]      cd_ray,
  output logic [31:0]      cd_tbest,
  input  logic [31:0]      cd_tnew,
  input  logic             cd_collide,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [IDX_W-1:0] hit_index,
  output logic [31:0]      t_hit
);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StEval, StDone} state_e;

  localparam logic [IDX_W:0] MaxCount = (IDX_W+1)'(MAX_SPHERES);
  localparam logic [IDX_W:0] CountOne = (IDX_W+1)'(1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [95:0]      origin_q, origin_d;
  logic [95:0]      dir_q, dir_d;
  logic [95:0]      cd_sphere_q, cd_sphere_d;
  logic [31:0]      tbest_q, tbest_d;
  logic             hit_q, hit_d;
  logic [IDX_W-1:0] hit_index_q, hit_index_d;
  logic [31:0]      t_hit_q, t_hit_d;

  logic [IDX_W:0]   num_clamped;
  logic             last;
  logic             accept;

  assign num_clamped = (num_spheres > MaxCount) ? MaxCount : num_spheres;
  assign last        = ({1'b0, idx_q} == (count_q - CountOne));
  assign accept      = cd_collide && ($signed(cd_tnew) > $signed(TMIN)) &&
                       ($signed(cd_tnew) < $signed(tbest_q));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    count_d     = count_q;
    origin_d    = origin_q;
    dir_d       = dir_q;
    cd_sphere_d = cd_sphere_q;
    tbest_d     = tbest_q;
    hit_d       = hit_q;
    hit_index_d = hit_index_q;
    t_hit_d     = t_hit_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          origin_d    = ray_origin;
          dir_d       = ray_dir;
          count_d     = num_clamped;
          idx_d       = '0;
          hit_d       = 1'b0;
          hit_index_d = '0;
          tbest_d     = TMAX;
          state_d     = (num_clamped == '0) ? StDone : StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        // Per-component wrap-around subtraction, no saturation.
        for (int i = 0; i < 3; i++) begin
          cd_sphere_d[32*i +: 32] = sphere_data[32*i +: 32] - origin_q[32*i +: 32];
        end
        state_d = StEval;
      end
      StEval: begin
        // Strict less-than: on a tie the earlier (lower) index is kept.
        if (accept) begin
          tbest_d     = cd_tnew;
          hit_index_d = idx_q;
          hit_d       = 1'b1;
        end
        if (last) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = StFetch;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Capture on entry to DONE so t_hit is already valid while done is high.
    if (state_d == StDone) begin
      t_hit_d = tbest_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      count_q     <= '0;
      origin_q    <= '0;
      dir_q       <= '0;
      cd_sphere_q <= '0;
      tbest_q     <= TMAX;
      hit_q       <= 1'b0;
      hit_index_q <= '0;
      t_hit_q     <= TMAX;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      origin_q    <= origin_d;
      dir_q       <= dir_d;
      cd_sphere_q <= cd_sphere_d;
      tbest_q     <= tbest_d;
      hit_q       <= hit_d;
      hit_index_q <= hit_index_d;
      t_hit_q     <= t_hit_d;
    end
  end

  assign sphere_addr = idx_q;
  assign cd_sphere   = cd_sphere_q;
  assign cd_ray      = dir_q;
  assign cd_tbest    = tbest_q;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign hit         = hit_q;
  assign hit_index   = hit_index_q;
  assign t_hit       = t_hit_q;

endmodule

// File: tb/tb_sphere_hit_scanner.sv
// Scoreboard bench for sphere_hit_scanner: each start pushes the expected
// result and done cycle; a monitor pops and compares on every done pulse.
module tb_sphere_hit_scanner;

  localparam logic [31:0] TMAX = 32'h7FFF_FFFF;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [95:0] ray_origin = '0;
  logic [95:0] ray_dir = '0;
  logic [4:0]  num_spheres = '0;
  logic [3:0]  sphere_addr;
  logic [95:0] sphere_data = '0;
  logic [95:0] cd_sphere;
  logic [95:0] cd_ray;
  logic [31:0] cd_tbest;
  logic [31:0] cd_tnew;
  logic        cd_collide;
  logic        busy;
  logic        done;
  logic        hit;
  logic [3:0]  hit_index;
  logic [31:0] t_hit;

  sphere_hit_scanner dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .ray_origin  (ray_origin),
    .ray_dir     (ray_dir),
    .num_spheres (num_spheres),
    .sphere_addr (sphere_addr),
    .sphere_data (sphere_data),
    .cd_sphere   (cd_sphere),
    .cd_ray      (cd_ray),
    .cd_tbest    (cd_tbest),
    .cd_tnew     (cd_tnew),
    .cd_collide  (cd_collide),
    .busy        (busy),
    .done        (done),
    .hit         (hit),
    .hit_index   (hit_index),
    .t_hit       (t_hit)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Sphere table (registered read) and collision model keyed by address.
  logic [95:0] mem  [16];
  logic        col  [16];
  logic [31:0] tnew [16];
  always @(posedge Clk) sphere_data <= mem[sphere_addr];
  assign cd_collide = col[sphere_addr];
  assign cd_tnew    = tnew[sphere_addr];

  typedef struct {
    logic       hit;
    logic [3:0] idx;
    logic [31:0] t;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;
  int   s_cyc = 0;
  int   done_seen = 0;

  function automatic logic [95:0] vec(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return {z, y, x};
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 16; i++) begin
      mem[i]  = '0;
      col[i]  = 1'b0;
      tnew[i] = '0;
    end
  endtask

  // Returns on the negedge of the cycle after the start cycle; lat < 0 means
  // no done is expected for this scan.
  task automatic issue(input logic [95:0] org, input logic [95:0] dir, input logic [4:0] n,
                       input logic eh, input logic [3:0] ei, input logic [31:0] et,
                       input int lat);
    exp_t e;
    @(negedge Clk);
    ray_origin  = org;
    ray_dir     = dir;
    num_spheres = n;
    start       = 1'b1;
    s_cyc       = cyc;
    if (lat >= 0) begin
      e.hit = eh; e.idx = ei; e.t = et; e.cyc = s_cyc + lat;
      sb.push_back(e);
    end
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge Clk);
      k++;
    end
    if (!done) begin
      n_total++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge Clk);
  endtask

  always @(negedge Clk) begin
    if (done) begin
      done_seen++;
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: done at cycle %0d with nothing expected", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", 96'(cyc), 96'(mon_e.cyc));
        chk("hit", 96'(hit), 96'(mon_e.hit));
        chk("hit_index", 96'(hit_index), 96'(mon_e.idx));
        chk("t_hit", 96'(t_hit), 96'(mon_e.t));
      end
    end
  end

  initial begin
    clear_tables();
    repeat (3) @(negedge Clk);
    chk("rst_busy", 96'(busy), 96'(0));
    chk("rst_done", 96'(done), 96'(0));
    chk("rst_hit", 96'(hit), 96'(0));
    chk("rst_hit_index", 96'(hit_index), 96'(0));
    chk("rst_t_hit", 96'(t_hit), 96'(TMAX));
    chk("rst_addr", 96'(sphere_addr), 96'(0));
    chk("rst_tbest", 96'(cd_tbest), 96'(TMAX));
    chk("rst_cd_sphere", cd_sphere, 96'(0));
    chk("rst_cd_ray", cd_ray, 96'(0));
    Reset = 1'b0;

    // 1: empty table, done one cycle after start
    issue('0, '0, 5'd0, 1'b0, 4'd0, TMAX, 1);
    wait_done(10);
    chk("empty_addr", 96'(sphere_addr), 96'(0));

    // 2: single hit, issued in the IDLE cycle right after the previous DONE
    mem[0] = vec(32'h0, 32'h0, 32'h0040_0000);
    col[0] = 1'b1; tnew[0] = 32'h0020_0000;
    issue('0, vec(32'h0, 32'h0, 32'h0001_0000), 5'd1, 1'b1, 4'd0, 32'h0020_0000, 4);
    at(s_cyc + 3);
    chk("single_cd_sphere", cd_sphere, vec(32'h0, 32'h0, 32'h0040_0000));
    chk("single_cd_ray", cd_ray, vec(32'h0, 32'h0, 32'h0001_0000));
    wait_done(20);
    @(negedge Clk);
    chk("hold_done", 96'(done), 96'(0));
    chk("hold_busy", 96'(busy), 96'(0));
    chk("hold_hit", 96'(hit), 96'(1));
    chk("hold_t_hit", 96'(t_hit), 96'(32'h0020_0000));

    // 3: nearest of three
    clear_tables();
    col[0] = 1'b1; tnew[0] = 32'h0032_0000;
    col[1] = 1'b1; tnew[1] = 32'h0014_0000;
    col[2] = 1'b1; tnew[2] = 32'h0023_0000;
    issue('0, vec(32'h0, 32'h0, 32'h0001_0000), 5'd3, 1'b1, 4'd1, 32'h0014_0000, 10);
    at(s_cyc + 4);
    chk("tbest_after_0", 96'(cd_tbest), 96'(32'h0032_0000));
    at(s_cyc + 7);
    chk("tbest_after_1", 96'(cd_tbest), 96'(32'h0014_0000));
    wait_done(40);

    // 4: rejects (below TMIN, no collide, tie with current best TMAX), back to back
    clear_tables();
    col[0] = 1'b1; tnew[0] = 32'h0000_0080;
    col[1] = 1'b0; tnew[1] = 32'h0005_0000;
    col[2] = 1'b1; tnew[2] = TMAX;
    issue('0, '0, 5'd3, 1'b0, 4'd0, TMAX, 10);
    chk("start_clears_hit", 96'(hit), 96'(0));
    chk("start_clears_index", 96'(hit_index), 96'(0));
    chk("start_keeps_t_hit", 96'(t_hit), 96'(32'h0014_0000));
    chk("start_busy", 96'(busy), 96'(1));
    wait_done(40);

    // 5: origin offset, per-component subtraction with negative component
    clear_tables();
    mem[0] = vec(32'h000C_0000, 32'h0, 32'h0002_0000);
    issue(vec(32'h000A_0000, 32'hFFFC_0000, 32'h0002_0000), '0, 5'd1,
          1'b0, 4'd0, TMAX, 4);
    at(s_cyc + 3);
    chk("offset_cd_sphere", cd_sphere, vec(32'h0002_0000, 32'h0004_0000, 32'h0));
    wait_done(20);

    // Clamp of count 31 to 16; TMIN boundary, negative distance and tie rejected
    clear_tables();
    col[3]  = 1'b1; tnew[3]  = 32'h0000_0100;
    col[4]  = 1'b1; tnew[4]  = 32'h0003_0000;
    col[7]  = 1'b1; tnew[7]  = 32'hFFFF_0000;
    col[15] = 1'b1; tnew[15] = 32'h0003_0000;
    issue('0, '0, 5'd31, 1'b1, 4'd4, 32'h0003_0000, 49);
    wait_done(80);

    // 6: start during FETCH ignored; single done at cycle 13
    clear_tables();
    issue('0, '0, 5'd4, 1'b0, 4'd0, TMAX, 13);
    num_spheres = 5'd0;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    wait_done(40);

    // Reset in EVAL of index 2 aborts the scan
    col[0] = 1'b1; tnew[0] = 32'h0009_0000;
    mem[1] = vec(32'h1, 32'h2, 32'h3);
    issue(vec(32'h1, 32'h1, 32'h1), vec(32'h5, 32'h6, 32'h7), 5'd4, 1'b0, 4'd0, TMAX, -1);
    at(s_cyc + 9);
    chk("pre_reset_busy", 96'(busy), 96'(1));
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    done_seen = 0;
    chk("abort_busy", 96'(busy), 96'(0));
    chk("abort_t_hit", 96'(t_hit), 96'(TMAX));
    chk("abort_hit", 96'(hit), 96'(0));
    chk("abort_tbest", 96'(cd_tbest), 96'(TMAX));
    chk("abort_cd_sphere", cd_sphere, 96'(0));
    chk("abort_cd_ray", cd_ray, 96'(0));
    repeat (20) @(negedge Clk);
    chk("abort_no_done", 96'(done_seen), 96'(0));
    chk("abort_idle_busy", 96'(busy), 96'(0));
    chk("scoreboard_empty", 96'(sb.size()), 96'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sphere_hit_scanner.md
Name: sphere_hit_scanner

Overview:
- Sequential stage directly upstream of the per-sphere ray/sphere collision unit.
- On each start it latches one ray and walks the sphere table, one sphere at a time.
- For each sphere it presents the sphere centre, relative to the ray origin, plus the running best distance to the collision unit, then keeps the nearest valid hit.
- It reports the nearest hit distance and sphere index to the shading stage.
- All reals are Q16.16 signed fixed point; vectors are 3 x 32 bits, with component 0 in bits [31:0].

Parameters:
- MAX_SPHERES, 16, sphere table depth.
- IDX_W, 4, sphere index width (log2 MAX_SPHERES).
- TMAX, 32'h7FFF_FFFF, "no hit" distance and initial tbest.
- TMIN, 32'h0000_0100, minimum accepted hit distance (1/256), to reject self-intersection.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- ray_origin  in  96  ray origin vector; latched on an accepted start.
- ray_dir  in  96  normalised ray direction; latched on an accepted start.
- num_spheres  in  IDX_W+1  count of valid table entries, 0..MAX_SPHERES; latched on an accepted start.
- sphere_addr  out  IDX_W  table read address.
- sphere_data  in  96  sphere centre; valid one cycle after sphere_addr.
- cd_sphere  out  96  registered relative centre (centre - origin) to the collision unit.
- cd_ray  out  96  latched ray_dir to the collision unit.
- cd_tbest  out  32  current best distance to the collision unit.
- cd_tnew  in  32  candidate distance from the collision unit.
- cd_collide  in  1  collision flag from the collision unit.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse when the result is valid.
- hit  out  1  at least one accepted hit in the last scan.
- hit_index  out  IDX_W  index of the nearest hit.
- t_hit  out  32  nearest hit distance; TMAX if there is no hit.

Behaviour:
- Reset values:
  - State is IDLE.
  - busy=0, done=0, hit=0, hit_index=0, t_hit=TMAX, sphere_addr=0, cd_tbest=TMAX.
  - cd_sphere=0; latched ray, origin and count are 0.
- Reset asserted mid-scan aborts immediately. No done pulse follows; outputs return to reset values on the next edge.
- States:
  - IDLE:
    - start=1 latches ray_origin, ray_dir and num_spheres.
    - It clears idx, hit and hit_index, and sets tbest=TMAX.
    - busy goes to 1. Next state is FETCH, or DONE if num_spheres=0.
  - FETCH: sphere_addr=idx. Next state is LOAD.
  - LOAD:
    - cd_sphere <= sphere_data - origin, per component, 32-bit wrap-around subtraction (no saturation).
    - Next state is EVAL.
  - EVAL:
    - The collision unit is combinational; cd_collide and cd_tnew are sampled at the end of this cycle.
    - Accept the candidate iff cd_collide=1 AND cd_tnew > TMIN (signed) AND cd_tnew < tbest (signed).
    - On accept: tbest <= cd_tnew, hit_index <= idx, hit <= 1.
    - Ties (cd_tnew == tbest) are rejected, so the lowest index wins.
    - If idx == num_spheres-1, next state is DONE; else idx <= idx+1 and next state is FETCH.
  - DONE:
    - t_hit <= tbest; done=1 for exactly this cycle; busy=0 from the next cycle.
    - Next state is IDLE.
- cd_tbest mirrors the tbest register at all times. cd_ray mirrors the latched direction.
- Latency: an accepted start at cycle 0 gives done at cycle 3N+1 for N>0, and at cycle 1 for N=0.
- start while not in IDLE (including DONE) is ignored.
- A start in the IDLE cycle directly after DONE is accepted.
- hit, hit_index and t_hit hold their values after done until the next accepted start.
  - hit and hit_index are cleared at that start.
  - t_hit keeps its previous value until the next DONE.
- num_spheres > MAX_SPHERES is clamped to MAX_SPHERES at latch.
- idx never wraps, because the terminal check uses the clamped count.

Test Plan:
1. Empty table:
   - Stimulus: num_spheres=0, start.
   - Required: done at cycle 1, hit=0, t_hit=32'h7FFF_FFFF, no FETCH address issued.
2. Single hit:
   - Stimulus: origin=0, dir=(0,0,1.0), sphere0 centre=(0,0,64.0); collision model returns collide=1, tnew=32.0 (32'h0020_0000).
   - Required: cd_sphere=(0,0,32'h0040_0000); done at cycle 4, hit=1, hit_index=0, t_hit=32'h0020_0000.
3. Nearest of three:
   - Stimulus: model returns tnew 50.0, 20.0, 35.0 for indices 0, 1, 2, all collide=1.
   - Required: tbest shows 50.0 then 20.0 on cd_tbest; final hit_index=1, t_hit=32'h0014_0000; done at cycle 10.
4. Rejects:
   - Stimulus: index 0 collide=1 with tnew=32'h0000_0080 (< TMIN); index 1 collide=0 with tnew=5.0; index 2 tnew equal to the prior best.
   - Required: no accepted hit from these, hit=0, t_hit=TMAX.
5. Origin offset:
   - Stimulus: origin=(10.0,-4.0,2.0), centre=(12.0,0,2.0).
   - Required: cd_sphere=(32'h0002_0000, 32'h0004_0000, 0) during EVAL.
6. Control:
   - Stimulus: start pulsed during FETCH of a 4-sphere scan; then Reset asserted in EVAL of index 2 of a new scan.
   - Required: the start is ignored and a single done appears at cycle 13. After Reset: busy=0, done never pulses, t_hit=TMAX, state IDLE.
